// File: rtl/shift_rows_pipe.sv
// ShiftRows / InvShiftRows for an Nb-column Rijndael state, direction picked per block.
// Latency: one register stage, 1 cycle from input handshake to out_valid.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); the held block is stable while stalled.
module shift_rows_pipe #(
   parameter  int NB      = 4,
   localparam int STATE_W = 32 * NB
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_inv,
   input  logic [STATE_W-1:0] state_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_inv,
   output logic [STATE_W-1:0] state_out
);

   // Only the three Rijndael block widths have defined row offsets.
   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   // Row rotation amount; the wide 256-bit block spreads rows 2 and 3 further apart.
   function automatic int row_shift(input int r);
      if (r == 0) return 0;
      if (NB == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   logic [STATE_W-1:0] fwd_state;
   logic [STATE_W-1:0] inv_state;
   logic [STATE_W-1:0] shifted;

   // Pure wiring: every output byte picks a fixed source byte, so both
   // directions are built in parallel and a single 2:1 mux selects one.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int S    = row_shift(r);
         localparam int DST  = (4 - r) * NB - 1 - c;
         localparam int FSRC = (4 - r) * NB - 1 - ((c + S) % NB);
         localparam int ISRC = (4 - r) * NB - 1 - ((c + NB - S) % NB);
         assign fwd_state[8*DST +: 8] = state_in[8*FSRC +: 8];
         assign inv_state[8*DST +: 8] = state_in[8*ISRC +: 8];
      end
   end

   assign shifted = in_inv ? inv_state : fwd_state;

   logic               out_valid_q, out_valid_d;
   logic               out_inv_q,   out_inv_d;
   logic [STATE_W-1:0] state_q,     state_d;
   logic               accept;
   logic               consume;

   // A slot frees up when the held block is consumed; flush blocks new entries.
   assign in_ready = !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid_q && out_ready;

   // Next-state: flush drops the held block, accept loads (also covers the
   // consume-and-accept cycle), a lone consume empties the stage, else hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_inv_d   = out_inv_q;
      state_d     = state_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_inv_d   = in_inv;
         state_d     = shifted;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register; reset clears everything, dropping any block in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_inv_q   <= 1'b0;
         state_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_inv_q   <= out_inv_d;
         state_q     <= state_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inv   = out_inv_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: three instances (NB=4,6,8) driven in lockstep,
// outputs compared against a row-rotation reference model.
module tb_shift_rows_pipe;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, in_inv, out_ready;
   logic [127:0] st4, o4;
   logic [191:0] st6, o6;
   logic [255:0] st8, o8;
   logic         ir4, ir6, ir8, ov4, ov6, ov8, oi4, oi6, oi8;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   shift_rows_pipe #(.NB(4)) u_nb4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
      .in_inv(in_inv), .state_in(st4), .out_valid(ov4), .out_ready(out_ready),
      .out_inv(oi4), .state_out(o4));
   shift_rows_pipe #(.NB(6)) u_nb6 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir6),
      .in_inv(in_inv), .state_in(st6), .out_valid(ov6), .out_ready(out_ready),
      .out_inv(oi6), .state_out(o6));
   shift_rows_pipe #(.NB(8)) u_nb8 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
      .in_inv(in_inv), .state_in(st8), .out_valid(ov8), .out_ready(out_ready),
      .out_inv(oi8), .state_out(o8));

   // Reference: pull each row out as a list of bytes, rotate it one step at a
   // time the required number of times, and pack it back.
   function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] s, input bit inv);
      logic [255:0] res;
      logic [7:0]   row [8];
      logic [7:0]   tmp;
      int           sh;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         sh = (r == 0) ? 0 : ((nb == 8 && r >= 2) ? r + 1 : r);
         for (int c = 0; c < nb; c++) row[c] = s[8*((4-r)*nb-1-c) +: 8];
         for (int k = 0; k < sh; k++) begin
            if (!inv) begin
               tmp = row[0];
               for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
               row[nb-1] = tmp;
            end else begin
               tmp = row[nb-1];
               for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
               row[0] = tmp;
            end
         end
         for (int c = 0; c < nb; c++) res[8*((4-r)*nb-1-c) +: 8] = row[c];
      end
      return res;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit inv, input logic [255:0] a8,
                        input logic [255:0] a6, input logic [255:0] a4);
      in_valid = v;
      in_inv   = inv;
      st8      = a8;
      st6      = a6[191:0];
      st4      = a4[127:0];
   endtask

   // Valid, direction tag and data of all three instances against expectations.
   task automatic chk_out(input string tag, input bit v, input bit inv, input logic [255:0] e8,
                          input logic [255:0] e6, input logic [255:0] e4);
      chk({tag, "_vld8"}, ov8, v);
      chk({tag, "_vld6"}, ov6, v);
      chk({tag, "_vld4"}, ov4, v);
      if (v) begin
         chk({tag, "_inv8"}, oi8, inv);
         chk({tag, "_inv6"}, oi6, inv);
         chk({tag, "_inv4"}, oi4, inv);
         chk({tag, "_dat8"}, o8, e8);
         chk({tag, "_dat6"}, o6, e6);
         chk({tag, "_dat4"}, o4, e4);
      end
   endtask

   task automatic chk_rdy(input string tag, input bit r);
      chk({tag, "_rdy8"}, ir8, r);
      chk({tag, "_rdy6"}, ir6, r);
      chk({tag, "_rdy4"}, ir4, r);
   endtask

   logic [255:0] a8, a6, a4, b8, b6, b4, h8, h6, h4;
   logic [255:0] q8 [8];
   logic [255:0] q6 [8];
   logic [255:0] q4 [8];
   bit           qi [8];
   bit           inv_r;

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 1'b0, '0, '0, '0);
      #3;
      // Reset state
      chk("rst_vld", {ov8, ov6, ov4}, 3'b000);
      chk("rst_inv", {oi8, oi6, oi4}, 3'b000);
      chk("rst_dat8", o8, '0);
      chk("rst_dat4", o4, '0);
      chk_rdy("rst", 1'b1);
      tick();
      reset = 1'b0;
      tick();
      chk_out("idle", 1'b0, 1'b0, '0, '0, '0);

      // Directed NB=4 vector, inverse then forward
      a4 = 256'h0F0E0D0C0B0A09080706050403020100;
      a6 = rnd256(); a6[255:192] = '0;
      a8 = rnd256();
      out_ready = 1'b1;
      drive(1'b1, 1'b1, a8, a6, a4);
      tick();
      chk("vec_inv4", o4, 256'h0F0E0D0C080B0A0905040706020100_03);
      chk_out("inv", 1'b1, 1'b1, ref_shift(8, a8, 1'b1), ref_shift(6, a6, 1'b1), ref_shift(4, a4, 1'b1));
      drive(1'b1, 1'b0, a8, a6, a4);
      tick();
      chk("vec_fwd4", o4, 256'h0F0E0D0C0A09080B0504070600030201);
      chk_out("fwd", 1'b1, 1'b0, ref_shift(8, a8, 1'b0), ref_shift(6, a6, 1'b0), ref_shift(4, a4, 1'b0));
      // Feed the forward result back through the inverse
      drive(1'b1, 1'b1, o8, {64'h0, o6}, {128'h0, o4});
      tick();
      chk_out("rt1", 1'b1, 1'b1, a8, a6, a4);

      // NB=8 byte-index pattern
      for (int i = 0; i < 32; i++) a8[8*i +: 8] = 8'(i);
      drive(1'b1, 1'b0, a8, a6, a4);
      tick();
      chk("idx8_row3", o8[63:0], 64'h0302010007060504);
      chk("idx8_row2", o8[127:64], 64'h0C0B0A09080F0E0D);
      chk("idx8_ref", o8, ref_shift(8, a8, 1'b0));
      drive(1'b1, 1'b1, o8, {64'h0, o6}, {128'h0, o4});
      tick();
      chk("idx8_rt", o8, a8);

      // Random round trips for every width
      for (int n = 0; n < 6; n++) begin
         a8 = rnd256(); a6 = rnd256(); a6[255:192] = '0; a4 = rnd256(); a4[255:128] = '0;
         drive(1'b1, 1'b0, a8, a6, a4);
         tick();
         chk_out("rnd_fwd", 1'b1, 1'b0, ref_shift(8, a8, 1'b0), ref_shift(6, a6, 1'b0), ref_shift(4, a4, 1'b0));
         drive(1'b1, 1'b1, o8, {64'h0, o6}, {128'h0, o4});
         tick();
         chk_out("rnd_rt", 1'b1, 1'b1, a8, a6, a4);
      end

      // Back-to-back: one block per cycle, in order
      for (int n = 0; n < 8; n++) begin
         q8[n] = rnd256(); q6[n] = rnd256(); q6[n][255:192] = '0;
         q4[n] = rnd256(); q4[n][255:128] = '0; qi[n] = 1'($urandom_range(0, 1));
      end
      for (int n = 0; n < 8; n++) begin
         drive(1'b1, qi[n], q8[n], q6[n], q4[n]);
         tick();
         chk_rdy("b2b", 1'b1);
         chk_out("b2b", 1'b1, qi[n], ref_shift(8, q8[n], qi[n]),
                 ref_shift(6, q6[n], qi[n]), ref_shift(4, q4[n], qi[n]));
      end

      // Backpressure: block A held for 5 cycles while B waits
      a8 = rnd256(); a6 = rnd256(); a6[255:192] = '0; a4 = rnd256(); a4[255:128] = '0;
      b8 = rnd256(); b6 = rnd256(); b6[255:192] = '0; b4 = rnd256(); b4[255:128] = '0;
      inv_r = 1'($urandom_range(0, 1));
      drive(1'b1, inv_r, a8, a6, a4);
      tick();
      out_ready = 1'b0;
      drive(1'b1, ~inv_r, b8, b6, b4);
      for (int n = 0; n < 5; n++) begin
         tick();
         chk_rdy("stall", 1'b0);
         chk_out("stall", 1'b1, inv_r, ref_shift(8, a8, inv_r), ref_shift(6, a6, inv_r), ref_shift(4, a4, inv_r));
      end
      out_ready = 1'b1;
      #1;
      chk_rdy("release", 1'b1);
      tick();
      chk_out("release", 1'b1, ~inv_r, ref_shift(8, b8, ~inv_r), ref_shift(6, b6, ~inv_r), ref_shift(4, b4, ~inv_r));
      drive(1'b0, 1'b0, '0, '0, '0);
      tick();
      chk_out("drain", 1'b0, 1'b0, '0, '0, '0);

      // Asynchronous reset in the middle of a stall
      drive(1'b1, 1'b1, b8, b6, b4);
      tick();
      out_ready = 1'b0;
      drive(1'b0, 1'b0, '0, '0, '0);
      tick();
      chk_out("pre_arst", 1'b1, 1'b1, ref_shift(8, b8, 1'b1), ref_shift(6, b6, 1'b1), ref_shift(4, b4, 1'b1));
      #2;
      reset = 1'b1;
      #1;
      chk("arst_vld", {ov8, ov6, ov4}, 3'b000);
      chk("arst_inv", {oi8, oi6, oi4}, 3'b000);
      chk("arst_dat8", o8, '0);
      chk("arst_dat6", o6, '0);
      chk("arst_dat4", o4, '0);
      chk_rdy("arst", 1'b1);
      tick();
      reset = 1'b0;
      tick();
      chk_out("post_arst", 1'b0, 1'b0, '0, '0, '0);

      // Flush drops the held block and a simultaneous input
      out_ready = 1'b1;
      drive(1'b1, 1'b0, a8, a6, a4);
      tick();
      h8 = ref_shift(8, a8, 1'b0); h6 = ref_shift(6, a6, 1'b0); h4 = ref_shift(4, a4, 1'b0);
      chk_out("pre_flush", 1'b1, 1'b0, h8, h6, h4);
      flush = 1'b1;
      drive(1'b1, 1'b1, b8, b6, b4);
      #1;
      chk_rdy("flush", 1'b0);
      tick();
      chk_out("flush", 1'b0, 1'b0, '0, '0, '0);
      chk("flush_hold8", o8, h8);
      chk("flush_hold4", o4, h4);
      flush = 1'b0;
      drive(1'b0, 1'b0, '0, '0, '0);
      tick();
      chk_out("flush_drop", 1'b0, 1'b0, '0, '0, '0);
      chk("flush_keep6", o6, h6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
